// File: rtl/pc_unit.sv
// Fetch-stage program counter for the pipelined MIPS core.
// Selects the next F-stage PC from reset, interrupt entry, exception return,
// branch/jump redirect, stall hold or sequential increment. A redirect that
// arrives while the fetch stage is stalled is buffered (HOLD) and applied on
// the first unstalled edge.
// Optional feature: define PC_RANGE_CHECK_EN to build the fetch address
// error check driving adel_o; otherwise adel_o is tied low.
module pc_unit #(
  parameter int unsigned      WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = 32'h0000_3000,
  parameter logic [WIDTH-1:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [WIDTH-1:0] TEXT_LO    = 32'h0000_3000,
  parameter logic [WIDTH-1:0] TEXT_HI    = 32'h0000_6FFC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             IntReq,
  input  logic             eret,
  input  logic [WIDTH-1:0] epc_i,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] F_PC_o,
  output logic [WIDTH-1:0] F_PC4_o,
  output logic             pend_o,
  output logic             adel_o
);

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHold = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic [WIDTH-1:0] pc_plus4;

  // Sequential successor; carry out of the top bit is dropped.
  assign pc_plus4 = pc_q + WIDTH'(4);

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StRun;
      pc_q      <= RESET_PC;
      pend_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
    end
  end

  // Next-PC selection, highest priority first (reset handled in the register).
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    if (IntReq) begin
      // Interrupt entry discards any buffered redirect and ignores stall.
      pc_d    = HANDLER_PC;
      state_d = StRun;
    end else if (eret) begin
      pc_d    = epc_i;
      state_d = StRun;
    end else if (stall) begin
      // Hold the PC; a newer redirect overwrites an older buffered one.
      if (redirect_valid) begin
        pend_pc_d = redirect_pc;
        state_d   = StHold;
      end
    end else if (redirect_valid) begin
      // A live redirect beats a buffered one.
      pc_d    = redirect_pc;
      state_d = StRun;
    end else if (state_q == StHold) begin
      pc_d    = pend_pc_q;
      state_d = StRun;
    end else begin
      pc_d = pc_plus4;
    end
  end

  assign F_PC_o  = pc_q;
  assign F_PC4_o = pc_plus4;
  assign pend_o  = (state_q == StHold);

`ifdef PC_RANGE_CHECK_EN
  // Misaligned or outside the text segment (unsigned compare).
  always_comb begin
    adel_o = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
  end
`else
  assign adel_o = 1'b0;
`endif

endmodule
